// File: rtl/vldst_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vldst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam int DEF_AW    = 16;
  localparam int DEF_DW    = 16;
  localparam int DEF_NELEM = 16;

endpackage

// File: rtl/vldst_addr_gen.sv
// Running-address accumulator and element counter for vldst_seq.
module vldst_addr_gen
  import vldst_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int NELEM = DEF_NELEM,
  localparam int EW   = $clog2(NELEM)
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          clear,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] addr,
  output logic [EW-1:0] idx,
  output logic          last
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk1) begin
    if (Reset || clear) begin
      addr <= '0;
      idx  <= '0;
    end else if (load) begin
      addr <= base;
      idx  <= '0;
    end else if (advance) begin
      addr <= addr + stride;
      idx  <= idx + 1'b1;
    end
  end

  assign last = (idx == EW'(NELEM - 1));

endmodule

// File: rtl/vldst_seq.sv
// Vector load/store sequencer: streams NELEM elements between memory and a vreg.
// Optional VLDST_STRIDE_EN adds a stride port; otherwise the address step is 1.
module vldst_seq
  import vldst_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int NELEM = DEF_NELEM,
  localparam int EW   = $clog2(NELEM)
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] base,
  input  logic [2:0]    vreg,
`ifdef VLDST_STRIDE_EN
  input  logic [AW-1:0] stride,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] MemAddr,
  output logic          MemRD,
  output logic          MemWR,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemRdy,
  output logic [2:0]    VAddr,
  output logic [EW-1:0] VRElem,
  input  logic [DW-1:0] VRData,
  output logic          VWE,
  output logic [EW-1:0] VWElem,
  output logic [DW-1:0] VWData
);

  state_t        state_q, state_d;
  logic          op_q;
  logic [2:0]    vreg_q;
  logic          pend_q;
  logic [EW-1:0] pend_idx_q;
  logic [AW-1:0] step;
  logic [AW-1:0] addr;
  logic [EW-1:0] idx;
  logic          last;
  logic          accept;
  logic          take_start;

  assign take_start = (state_q == IDLE) && start;
  assign accept     = (state_q == ISSUE) && MemRdy;

`ifdef VLDST_STRIDE_EN
  logic [AW-1:0] stride_q;

  always_ff @(posedge Clk1) begin
    if (Reset)           stride_q <= '0;
    else if (take_start) stride_q <= stride;
  end

  assign step = stride_q;
`else
  assign step = AW'(1);
`endif

  // Accumulator is zeroed in DONE so MemAddr sits at 0 again once idle.
  vldst_addr_gen #(
    .AW    (AW),
    .NELEM (NELEM)
  ) u_addr_gen (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .clear   (state_q == DONE),
    .load    (take_start),
    .advance (accept),
    .base    (base),
    .stride  (step),
    .addr    (addr),
    .idx     (idx),
    .last    (last)
  );

  // NOTE: next-state is defaulted to the current state before the case so
  // no path through the block leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (MemRdy && last) state_d = (op_q == OP_LOAD) ? DRAIN : DONE;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD;
      vreg_q     <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_start) begin
        op_q   <= op;
        vreg_q <= vreg;
      end
      // Each accepted load element is written back in the following cycle.
      pend_q <= accept && (op_q == OP_LOAD);
      if (accept) pend_idx_q <= idx;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign MemRD    = (state_q == ISSUE) && (op_q == OP_LOAD);
  assign MemWR    = (state_q == ISSUE) && (op_q == OP_STORE);
  assign MemAddr  = addr;
  assign MemWData = MemWR ? VRData : '0;
  assign VAddr    = vreg_q;
  assign VRElem   = idx;
  assign VWE      = pend_q;
  assign VWElem   = pend_idx_q;
  assign VWData   = pend_q ? MemRData : '0;

endmodule

// File: tb/tb_vldst_seq.sv
// Scoreboard bench for vldst_seq: stimulus pushes expected requests, write-backs
// and done pulses; a negedge monitor pops and compares. Build with VLDST_STRIDE_EN to cover stride.
`timescale 1ns/1ps
module tb_vldst_seq;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int NELEM = 16;
  localparam int EW    = 4;

  logic          Clk1 = 1'b0;
  logic          Reset;
  logic          start;
  logic          op;
  logic [AW-1:0] base;
  logic [2:0]    vreg;
`ifdef VLDST_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy, done, MemRD, MemWR, MemRdy, VWE;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWData, MemRData, VRData, VWData;
  logic [2:0]    VAddr;
  logic [EW-1:0] VRElem, VWElem;

  logic [DW-1:0] vr_mem [NELEM];
  logic [DW-1:0] mem_key;
  int            rdy_mode;
  logic [2:0]    exp_vreg;

  assign VRData = vr_mem[VRElem];

  vldst_seq dut (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .start    (start),
    .op       (op),
    .base     (base),
    .vreg     (vreg),
`ifdef VLDST_STRIDE_EN
    .stride   (stride),
`endif
    .busy     (busy),
    .done     (done),
    .MemAddr  (MemAddr),
    .MemRD    (MemRD),
    .MemWR    (MemWR),
    .MemWData (MemWData),
    .MemRData (MemRData),
    .MemRdy   (MemRdy),
    .VAddr    (VAddr),
    .VRElem   (VRElem),
    .VRData   (VRData),
    .VWE      (VWE),
    .VWElem   (VWElem),
    .VWData   (VWData)
  );

  always #5 Clk1 = ~Clk1;

  typedef struct { logic is_store; logic [AW-1:0] addr; logic [DW-1:0] wdata; } req_t;
  typedef struct { logic [EW-1:0] elem; logic [DW-1:0] data; int cyc; } wb_t;
  typedef struct { logic is_store; int cyc; } done_t;

  req_t  req_q[$];
  wb_t   wb_q[$];
  done_t done_q[$];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic flush();
    req_q.delete();
    wb_q.delete();
    done_q.delete();
  endtask

  initial forever begin
    @(posedge Clk1);
    cyc++;
  end

  // Memory responder: a read accepted at an edge returns addr^key in the next cycle.
  initial begin
    logic [DW-1:0] rd_next;
    logic          tog;
    rd_next  = '0;
    tog      = 1'b0;
    MemRData = '0;
    MemRdy   = 1'b0;
    forever begin
      @(posedge Clk1);
      if (MemRD && MemRdy && !Reset) rd_next = MemAddr ^ mem_key;
      #1;
      MemRData = rd_next;
      case (rdy_mode)
        0:       MemRdy = 1'b1;
        1:       begin tog = ~tog; MemRdy = tog; end
        default: MemRdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare whatever the DUT presents against the scoreboard heads.
  initial forever begin
    @(negedge Clk1);
    if (!Reset) begin
      if (busy) check("vaddr", VAddr, exp_vreg);
      if (MemRD || MemWR) begin
        check("rd_wr_exclusive", MemRD & MemWR, 1'b0);
        if (req_q.size() == 0) fail_now("spurious_req");
        else begin
          check("req_type", MemWR, req_q[0].is_store);
          check("req_addr", MemAddr, req_q[0].addr);
          if (req_q[0].is_store) check("req_wdata", MemWData, req_q[0].wdata);
          if (MemRdy) begin
            void'(req_q.pop_front());
            last_acc = cyc;
          end
        end
      end
      if (VWE) begin
        if (wb_q.size() == 0) fail_now("spurious_wb");
        else begin
          wb_t w;
          w = wb_q.pop_front();
          check("wb_elem", VWElem, w.elem);
          check("wb_data", VWData, w.data);
          if (w.cyc >= 0) check("wb_cycle", cyc, w.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail_now("spurious_done");
        else begin
          done_t d;
          d = done_q.pop_front();
          check("done_after_last_accept", cyc, last_acc + (d.is_store ? 1 : 2));
          if (d.cyc >= 0) check("done_cycle", cyc, d.cyc);
          check("reqs_left_at_done", req_q.size(), 0);
          check("wbs_left_at_done", wb_q.size(), 0);
        end
      end
    end
  end

  // Expected behaviour: element k at base + k*stride; load data = addr ^ key.
  task automatic issue_cmd(input logic o, input logic [AW-1:0] b, input logic [2:0] v,
                           input logic [AW-1:0] s, input int mode);
    int c;
`ifndef VLDST_STRIDE_EN
    s = AW'(1);
`endif
    c        = cyc;
    rdy_mode = mode;
    exp_vreg = v;
    for (int k = 0; k < NELEM; k++) begin
      req_t r;
      logic [AW-1:0] a;
      a = b + AW'(k) * s;
      r.is_store = o;
      r.addr     = a;
      r.wdata    = vr_mem[k];
      req_q.push_back(r);
      if (!o) begin
        wb_t w;
        w.elem = EW'(k);
        w.data = a ^ mem_key;
        w.cyc  = (mode == 0) ? c + 2 + k : -1;
        wb_q.push_back(w);
      end
    end
    begin
      done_t d;
      d.is_store = o;
      d.cyc      = (mode == 0) ? c + NELEM + (o ? 1 : 2) : -1;
      done_q.push_back(d);
    end
    start = 1'b1;
    op    = o;
    base  = b;
    vreg  = v;
`ifdef VLDST_STRIDE_EN
    stride = s;
`endif
    @(posedge Clk1); #1;
    start = 1'b0;
    op    = 1'($urandom);
    base  = AW'($urandom);
    vreg  = 3'($urandom);
`ifdef VLDST_STRIDE_EN
    stride = AW'($urandom);
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(posedge Clk1); #1;
      n++;
    end
    if (n >= 400) begin
      $display("FAIL timeout: busy still 1 after %0d cycles, expected 0", n);
      n_vec++;
      n_fail++;
      flush();
    end
    check("done_seen", done_q.size(), 0);
    @(posedge Clk1); #1;
  endtask

  task automatic run_cmd(input logic o, input logic [AW-1:0] b, input logic [2:0] v,
                         input logic [AW-1:0] s, input int mode);
    issue_cmd(o, b, v, s, mode);
    wait_idle();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_rd"},    MemRD, 1'b0);
    check({tag, "_wr"},    MemWR, 1'b0);
    check({tag, "_addr"},  MemAddr, '0);
    check({tag, "_wdata"}, MemWData, '0);
    check({tag, "_vwe"},   VWE, 1'b0);
    check({tag, "_vrel"},  VRElem, '0);
    check({tag, "_vwel"},  VWElem, '0);
    check({tag, "_vaddr"}, VAddr, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    Reset    = 1'b1;
    start    = 1'b0;
    op       = 1'b0;
    base     = '0;
    vreg     = '0;
`ifdef VLDST_STRIDE_EN
    stride   = '0;
`endif
    rdy_mode = 0;
    exp_vreg = '0;
    mem_key  = 16'hA5A5;
    for (int k = 0; k < NELEM; k++) vr_mem[k] = DW'(16'h1000 + k);
    repeat (3) @(posedge Clk1);
    #1;
    Reset = 1'b0;
    check_idle_outputs("reset");
    @(posedge Clk1); #1;

    // Load, all-ready: write-backs cycles 2..17, done cycle 18.
    run_cmd(1'b0, 16'h0100, 3'd3, 16'h0001, 0);

    // Store across the address wrap, data 0x1000+i, done cycle 17.
    run_cmd(1'b1, 16'hFFF8, 3'd5, 16'h0001, 0);

    // Load with MemRdy alternating.
    mem_key = 16'h3C3C;
    run_cmd(1'b0, 16'h0200, 3'd6, 16'h0001, 1);

    // Reset during cycle 8 of a load, then a fresh command.
    issue_cmd(1'b0, 16'h0300, 3'd2, 16'h0001, 0);
    repeat (7) @(posedge Clk1);
    #1;
    Reset = 1'b1;
    @(posedge Clk1); #1;
    Reset = 1'b0;
    flush();
    check_idle_outputs("midreset");
    @(posedge Clk1); #1;
    check("midreset_vwe_next", VWE, 1'b0);
    run_cmd(1'b0, 16'h0400, 3'd1, 16'h0001, 0);

    // start pulsed as a store while a load is busy must be ignored.
    issue_cmd(1'b0, 16'h0500, 3'd4, 16'h0001, 0);
    repeat (4) @(posedge Clk1);
    #1;
    start = 1'b1;
    op    = 1'b1;
    base  = 16'h0040;
    vreg  = 3'd7;
    @(posedge Clk1); #1;
    start = 1'b0;
    wait_idle();

`ifdef VLDST_STRIDE_EN
    run_cmd(1'b0, 16'h0000, 3'd2, 16'h0010, 0);
    run_cmd(1'b1, 16'h1234, 3'd3, 16'h0000, 2);
    run_cmd(1'b0, 16'hFF00, 3'd4, 16'h0123, 1);
`endif

    for (int n = 0; n < 16; n++) begin
      mem_key = DW'($urandom);
      for (int k = 0; k < NELEM; k++) vr_mem[k] = DW'($urandom);
      run_cmd(1'($urandom), AW'($urandom), 3'($urandom),
              ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vldst_seq.md
# vldst_seq

Vector load/store sequencer for the CVP14 datapath. It takes one VLD or VST command and streams all vector elements between system memory and the serial port of the vector register file. It generates the per-element memory addresses and the request handshake, and routes data to or from the selected vector register. It sits between the instruction controller (upstream) and the vector register file and memory bus (downstream).

## Interface
Parameters:
- AW, 16: memory address width.
- DW, 16: data width, which is also the element width.
- NELEM, 16: elements per vector. Must be a power of two.

Ports:
- Clk1  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command strobe; sampled only when idle.
- op  in  1  0 = load (memory to vreg), 1 = store (vreg to memory).
- base  in  AW  start address; captured on accepted start.
- vreg  in  3  vector register index; captured on accepted start.
- stride  in  AW  address increment. Present only with VLDST_STRIDE_EN.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- MemAddr  out  AW  request address.
- MemRD / MemWR  out  1  read / write request.
- MemWData  out  DW  write data.
- MemRData  in  DW  read data.
- MemRdy  in  1  memory accepts request at this edge.
- VAddr  out  3  vector register select; equals the captured vreg.
- VRElem  out  log2(NELEM)  element read index (store).
- VRData  in  DW  combinational element read data.
- VWE  out  1  element write enable (load).
- VWElem  out  log2(NELEM)  element write index.
- VWData  out  DW  element write data.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 captures op, base, vreg (and stride).
  - Clears element counter i and the running address.
  - Moves to ISSUE.
- ISSUE:
  - Drives MemRD (load) or MemWR (store) high with MemAddr = current address.
  - Request and address are held until MemRdy=1 at a posedge (acceptance).
  - On acceptance: address += stride, i += 1.
  - After accepting element NELEM-1: load goes to DRAIN, store goes to DONE.
- Store data path:
  - VRElem = i.
  - MemWData = VRData, combinational, same cycle as the request.
- Load data path:
  - Acceptance of element k sets a pending flag with index k.
  - Next cycle: VWE=1, VWElem=k, VWData=MemRData (combinational pass).
  - Back-to-back acceptances give one write-back per cycle.
- DRAIN: performs the final write-back, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy is high in ISSUE, DRAIN and DONE.
- start is ignored while busy=1.
- Addresses are computed modulo 2^AW; wrap-around is silent.

## Timing
- Reset values: busy=0, done=0, MemRD=0, MemWR=0, MemAddr=0, MemWData=0, VWE=0, VRElem=0, VWElem=0, VAddr=0.
- Latency with MemRdy held at 1 and start accepted at edge 0:
  - Requests occupy cycles 1..NELEM.
  - Load: write-backs in cycles 2..NELEM+1; done in cycle NELEM+2.
  - Store: done in cycle NELEM+1.
- Wait states: each MemRdy=0 cycle extends the sequence by one cycle. No element is skipped or duplicated.
- Reset mid-command: the next cycle is IDLE with all outputs at reset values. A pending write-back is discarded, and no VWE is issued.
- VAddr is stable for the whole command.
- MemAddr changes only after acceptance or on return to IDLE.

## Configuration
- VLDST_STRIDE_EN defined:
  - The stride port exists and is captured on start.
  - Address for element i = base + i*stride mod 2^AW.
  - stride=0 is legal and repeats one address.
- VLDST_STRIDE_EN undefined:
  - No stride port; the increment is fixed at 1.

## Structure
- Package vldst_pkg holds:
  - State enum (IDLE, ISSUE, DRAIN, DONE).
  - OP_LOAD=0 and OP_STORE=1 constants.
  - Default NELEM and AW.
- Sub-module vldst_addr_gen holds:
  - The running-address accumulator and element counter, with clear/advance controls and a last-element flag.
  - The top level holds the FSM and the write-back pending register.

## Test plan
- Load, base=0x0100, vreg=3, MemRdy=1, mem[a]=a^0xA5A5 -> VWE in cycles 2..17, VWElem 0..15, VWData=(0x0100+k)^0xA5A5, VAddr=3, done in cycle 18.
- Store, base=0xFFF8, VRData=0x1000+VRElem -> MemAddr 0xFFF8..0xFFFF then 0x0000..0x0007, MemWData=0x1000+i, done in cycle 17.
- Load with MemRdy alternating 1,0 -> each address held through the stall; exactly 16 write-backs, in order; done 2 cycles after final acceptance.
- Reset asserted in cycle 8 of a load -> next cycle busy=0, MemRD=0, VWE=0; a fresh start afterwards completes normally.
- start pulsed while busy with op=1, base=0x0040 -> ignored; the original load completes unchanged.
- VLDST_STRIDE_EN, stride=0x0010, base=0 -> MemAddr 0x0000, 0x0010, ..., 0x00F0; with stride=0, all 16 requests go to base.
